// File: rtl/ctrl_pkg.sv
// +----------------------------------------------------------------------------+
// | ctrl_pkg: shared state, opcode and datapath-select encodings               |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_e;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] IMM_I = 2'd0;
  localparam logic [1:0] IMM_S = 2'd1;
  localparam logic [1:0] IMM_B = 2'd2;
  localparam logic [1:0] IMM_J = 2'd3;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_OLDPC = 2'd1;
  localparam logic [1:0] SRCA_RS1   = 2'd2;

  localparam logic [1:0] SRCB_RS2  = 2'd0;
  localparam logic [1:0] SRCB_IMM  = 2'd1;
  localparam logic [1:0] SRCB_FOUR = 2'd2;

  localparam logic [1:0] RES_ALUOUT    = 2'd0;
  localparam logic [1:0] RES_DATA      = 2'd1;
  localparam logic [1:0] RES_ALURESULT = 2'd2;

endpackage

`default_nettype wire

// File: rtl/alu_decoder.sv
// +----------------------------------------------------------------------------+
// | alu_decoder: funct3/funct7[5] to ALU operation, flags unsupported funct3   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module alu_decoder
  import ctrl_pkg::*;
(
  input  logic [2:0] i_funct3,
  input  logic       i_ins30,
  input  logic       i_is_rtype,
  output logic [2:0] o_alu_ctrl,
  output logic       o_valid
);

  always_comb begin
    o_alu_ctrl = ALU_ADD;
    o_valid    = 1'b1;
    case (i_funct3)
      // Immediate forms have no subtract; bit 30 is part of the immediate there.
      3'b000:  o_alu_ctrl = (i_is_rtype && i_ins30) ? ALU_SUB : ALU_ADD;
      3'b111:  o_alu_ctrl = ALU_AND;
      3'b110:  o_alu_ctrl = ALU_OR;
      3'b100:  o_alu_ctrl = ALU_XOR;
      3'b010:  o_alu_ctrl = ALU_SLT;
      default: o_valid    = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// +----------------------------------------------------------------------------+
// | multicycle_ctrl: multicycle RISC-V subset control FSM with retire counter  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      ins,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic             mem_write,
  output logic             adr_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       result_src,
  output logic [1:0]       imm_src,
  output logic [2:0]       alu_ctrl,
  output logic             illegal,
  output logic             retired,
  output logic [CNT_W-1:0] retire_cnt
);

  state_e           r_state;
  state_e           w_next;
  logic [6:0]       w_op;
  logic [2:0]       w_funct3;
  logic [2:0]       w_dec_alu;
  logic             w_dec_valid;
  logic             w_br_valid;
  logic [CNT_W-1:0] r_retire_cnt;
  logic             w_unused;

  assign w_op       = ins[6:0];
  assign w_funct3   = ins[14:12];
  assign w_br_valid = (w_funct3 == 3'b000) || (w_funct3 == 3'b001);
  assign w_unused   = ^{ins[31], ins[29:15], ins[11:7]};

  alu_decoder u_alu_decoder (
    .i_funct3   (w_funct3),
    .i_ins30    (ins[30]),
    .i_is_rtype (w_op == OP_R),
    .o_alu_ctrl (w_dec_alu),
    .o_valid    (w_dec_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:    w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (w_op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXECR;
          OP_I:         w_next = S_EXECI;
          OP_BR:        w_next = S_BRANCH;
          OP_JAL:       w_next = S_JAL;
          default:      w_next = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   w_next = (w_op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  w_next = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    w_next = S_FETCH;
      S_MEMWRITE: w_next = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECR,
      S_EXECI:    w_next = w_dec_valid ? S_ALUWB : S_ILLEGAL;
      S_ALUWB:    w_next = S_FETCH;
      S_BRANCH:   w_next = w_br_valid ? S_FETCH : S_ILLEGAL;
      S_JAL:      w_next = S_ALUWB;
      S_ILLEGAL:  w_next = S_ILLEGAL;
      default:    w_next = S_FETCH;
    endcase
  end

  // Everything is forced low during reset so an aborted access cannot strobe.
  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    result_src = RES_ALUOUT;
    imm_src    = IMM_I;
    alu_ctrl   = ALU_ADD;
    illegal    = 1'b0;
    retired    = 1'b0;
    if (!rst) begin
      case (r_state)
        S_FETCH: begin
          alu_src_b  = SRCB_FOUR;
          result_src = RES_ALURESULT;
          ir_write   = mem_ready;
          pc_write   = mem_ready;
        end
        S_DECODE: begin
          alu_src_a = SRCA_OLDPC;
          alu_src_b = SRCB_IMM;
          imm_src   = (w_op == OP_JAL) ? IMM_J : IMM_B;
        end
        S_MEMADR: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_IMM;
          imm_src   = (w_op == OP_SW) ? IMM_S : IMM_I;
        end
        S_MEMREAD: adr_src = 1'b1;
        S_MEMWB: begin
          result_src = RES_DATA;
          reg_write  = 1'b1;
          retired    = 1'b1;
        end
        S_MEMWRITE: begin
          adr_src   = 1'b1;
          mem_write = 1'b1;
          retired   = mem_ready;
        end
        S_EXECR: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_RS2;
          alu_ctrl  = w_dec_alu;
        end
        S_EXECI: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_IMM;
          imm_src   = IMM_I;
          alu_ctrl  = w_dec_alu;
        end
        S_ALUWB: begin
          reg_write = 1'b1;
          retired   = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_RS2;
          alu_ctrl  = ALU_SUB;
          pc_write  = w_br_valid && ((w_funct3[0]) ? !zero : zero);
          retired   = w_br_valid;
        end
        S_JAL: begin
          alu_src_a = SRCA_OLDPC;
          alu_src_b = SRCB_FOUR;
          pc_write  = 1'b1;
        end
        S_ILLEGAL: illegal = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_retire_cnt <= '0;
    end else if (retired) begin
      r_retire_cnt <= r_retire_cnt + CNT_W'(1);
    end
  end

  assign retire_cnt = r_retire_cnt;

endmodule

`default_nettype wire

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-002 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset; synchronous and active-high.
REQ-004 SHALL have port ins, input, 32: the instruction word held in the instruction register.
REQ-005 SHALL have port zero, input, 1: ALU zero flag.
REQ-006 SHALL have port mem_ready, input, 1: memory done, sampled in FETCH, MEMREAD and MEMWRITE.
REQ-007 SHALL have output ports pc_write, ir_write, reg_write, mem_write, adr_src, each 1 bit: datapath strobes and selects.
REQ-008 SHALL have output ports alu_src_a, alu_src_b, result_src, imm_src (2 bits each) and alu_ctrl (3 bits): datapath selects.
- imm_src: 0=I, 1=S, 2=B, 3=J.
- alu_ctrl: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT.
REQ-009 SHALL have output ports illegal (1), retired (1) and retire_cnt (CNT_W): status outputs.

Function
REQ-010 SHALL decode opcode ins[6:0]: 0000011 lw, 0100011 sw, 0110011 R-type, 0010011 I-ALU, 1100011 branch, 1101111 jal; any other value is illegal.
REQ-011 SHALL implement an FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, ILLEGAL.
REQ-012 FETCH SHALL drive adr_src=0, alu_src_a=0 (PC), alu_src_b=2 (const 4), alu_ctrl=ADD, result_src=2.
- ir_write=pc_write=mem_ready.
- Stay in FETCH while !mem_ready; go to DECODE otherwise.
REQ-013 DECODE SHALL drive alu_src_a=1 (old PC), alu_src_b=1 (imm), ADD, with imm_src=3 for jal and 2 otherwise.
- Next state: lw/sw to MEMADR, R to EXECR, I-ALU to EXECI, branch to BRANCH, jal to JAL, other to ILLEGAL.
REQ-014 MEMADR SHALL drive alu_src_a=2 (rs1), alu_src_b=1, ADD, with imm_src=0 for lw and 1 for sw.
- Next state: MEMREAD for lw, MEMWRITE for sw.
REQ-015 MEMREAD SHALL drive adr_src=1 and wait for mem_ready, then go to MEMWB.
REQ-016 MEMWB SHALL drive result_src=1 and reg_write=1, then go to FETCH.
REQ-017 MEMWRITE SHALL drive adr_src=1 and hold mem_write=1 until the cycle mem_ready=1 (inclusive), then go to FETCH.
REQ-018 EXECR SHALL drive alu_src_a=2, alu_src_b=0, then go to ALUWB.
- alu_ctrl from funct3: 000 ADD, or SUB when ins[30]=1; 111 AND; 110 OR; 100 XOR; 010 SLT.
- Other funct3 values go to ILLEGAL.
REQ-019 EXECI SHALL drive alu_src_a=2, alu_src_b=1, imm_src=0, then go to ALUWB.
- alu_ctrl is decoded as in REQ-018, except that ins[30] is ignored.
REQ-020 ALUWB SHALL drive result_src=0 and reg_write=1, then go to FETCH.
REQ-021 BRANCH SHALL drive alu_src_a=2, alu_src_b=0, SUB, result_src=0, then go to FETCH.
- funct3=000 (beq): pc_write=zero.
- funct3=001 (bne): pc_write=!zero.
- Other funct3 values go to ILLEGAL instead.
REQ-022 JAL SHALL drive alu_src_a=1, alu_src_b=2, ADD, result_src=0, pc_write=1, then go to ALUWB to write PC+4 to rd.
REQ-023 ILLEGAL SHALL hold illegal=1 with all strobes 0 until reset (sticky).
REQ-024 Unlisted outputs in any state SHALL be 0; strobes SHALL be combinational from state plus inputs.
REQ-025 retired SHALL pulse for one cycle on the final cycle of each instruction: MEMWB, MEMWRITE with mem_ready, ALUWB, BRANCH.
- retire_cnt SHALL increment on each pulse and wrap from all-ones to 0.

Reset
REQ-026 While rst=1, all strobes SHALL be 0; the next state SHALL be FETCH; illegal and retire_cnt SHALL be cleared to 0.
REQ-027 rst asserted mid-instruction (including MEMREAD or MEMWRITE waits) SHALL abort it with no strobe in the reset cycle and no retired pulse.

Structure
REQ-028 A shared package ctrl_pkg SHALL hold the state enum, opcode constants, the imm_src and alu_ctrl encodings, and the select encodings.
REQ-029 ALU-control decoding SHALL be a combinational sub-module alu_decoder (inputs: funct3, ins[30], is_rtype; output: alu_ctrl, valid).

Verification
REQ-030 ins=0x002081B3 (add), mem_ready=1 -> states FETCH, DECODE, EXECR, ALUWB; alu_ctrl=000 in EXECR; reg_write and retired in cycle 4; retire_cnt=1.
REQ-031 ins=0x40208133 (sub) -> alu_ctrl=001 in EXECR; ins=0x40000093 (addi) -> alu_ctrl=000 in EXECI.
REQ-032 beq 0x00208463 with zero=1 -> pc_write=1 in BRANCH; bne 0x00209463 with zero=1 -> pc_write=0; both retire.
REQ-033 lw 0x0000A183 with mem_ready held low 3 cycles in MEMREAD -> 4 cycles in MEMREAD, then MEMWB with reg_write=1; total 8 cycles.
REQ-034 ins=0x0000007F -> ILLEGAL after DECODE; illegal=1 held for 10 cycles; no strobes.
REQ-035 rst pulsed during MEMWRITE (sw 0x0020A023, mem_ready=0) -> mem_write=0 in the reset cycle, FETCH next cycle, retire_cnt=0, illegal=0.
